// File: rtl/updown_counter.sv
// updown_counter: prescaled up/down modulo counter with wrap/saturate modes and sticky overflow
module updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             ovf
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH:0] MOD = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]    psc;
    logic             step, bnd;
    logic [WIDTH-1:0] step_val, load_clamped;

    // next count for a step, and whether that step hits a range boundary
    always_comb begin
        step         = enable && psc == PMAX;
        bnd          = up ? count == MAX : count == '0;
        step_val     = bnd ? (sat_mode ? count : (up ? '0 : MAX)) : (up ? count + 1'b1 : count - 1'b1);
        load_clamped = {1'b0, load_val} >= MOD ? MAX : load_val;
    end

    // rst > load > step > hold; ovf is sticky and a boundary step beats clr_ovf
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            psc   <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            psc   <= '0;
            wrap  <= 1'b0;
        end else begin
            if (enable) psc <= psc == PMAX ? '0 : psc + 1'b1;
            if (step) count <= step_val;
            wrap <= step && bnd && !sat_mode;
            ovf  <= (step && bnd) || (ovf && !clr_ovf);
        end
    end
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed checks plus per-cycle model comparison for two counter configurations
module tb_updown_counter;
    localparam int M = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst = 1'b1, a_en = 1'b0, a_up = 1'b1, a_ld = 1'b0, a_sat = 1'b0, a_clr = 1'b0;
    logic [3:0] a_lv = '0;
    logic [3:0] a_count;
    logic       a_wrap, a_ovf;

    logic       b_rst = 1'b1, b_en = 1'b0;
    logic [3:0] b_count;
    logic       b_wrap, b_ovf;

    int tests = 0, fails = 0;

    updown_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(a_rst), .enable(a_en), .up(a_up), .load(a_ld), .load_val(a_lv),
        .sat_mode(a_sat), .clr_ovf(a_clr), .count(a_count), .wrap(a_wrap), .ovf(a_ovf)
    );

    updown_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(3)) dut_b (
        .clk(clk), .rst(b_rst), .enable(b_en), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .sat_mode(1'b0), .clr_ovf(1'b0), .count(b_count), .wrap(b_wrap), .ovf(b_ovf)
    );

    // reference model state per instance: count, enabled cycles into the current interval, wrap, ovf
    int mc[2], mp[2];
    bit mw[2], mo[2];
    bit chk[2] = '{1'b0, 1'b0};

    task automatic mdl(input int k, input int p, input bit r, input bit e, input bit u,
                       input bit l, input int lv, input bit s, input bit c);
        bit hit;
        if (r) begin
            mc[k] = 0; mp[k] = 0; mw[k] = 0; mo[k] = 0;
        end else if (l) begin
            mc[k] = lv >= M ? M - 1 : lv;
            mp[k] = 0;
            mw[k] = 0;
        end else begin
            hit = 0;
            mw[k] = 0;
            if (e) begin
                mp[k] = (mp[k] + 1) % p;
                if (mp[k] == 0) begin
                    hit = u ? mc[k] == M - 1 : mc[k] == 0;
                    if (!hit) mc[k] = mc[k] + (u ? 1 : -1);
                    else if (!s) begin
                        mc[k] = (mc[k] + (u ? 1 : -1) + M) % M;
                        mw[k] = 1;
                    end
                end
            end
            mo[k] = hit || (mo[k] && !c);
        end
    endtask

    always @(posedge clk) begin
        mdl(0, 1, a_rst, a_en, a_up, a_ld, int'(a_lv), a_sat, a_clr);
        mdl(1, 3, b_rst, b_en, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    end

    task automatic cmp(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // every cycle after reset, both instances must agree with the model
    always @(negedge clk) begin
        if (chk[0]) begin
            cmp("model_a_count", int'(a_count), mc[0]);
            cmp("model_a_wrap", int'(a_wrap), int'(mw[0]));
            cmp("model_a_ovf", int'(a_ovf), int'(mo[0]));
        end
        if (chk[1]) begin
            cmp("model_b_count", int'(b_count), mc[1]);
            cmp("model_b_wrap", int'(b_wrap), int'(mw[1]));
            cmp("model_b_ovf", int'(b_ovf), int'(mo[1]));
        end
    end

    task automatic a_chk(input string name, input int c, input int w, input int o);
        cmp({name, "_count"}, int'(a_count), c);
        cmp({name, "_wrap"}, int'(a_wrap), w);
        cmp({name, "_ovf"}, int'(a_ovf), o);
    endtask

    int exp_b[9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};

    initial begin
        @(negedge clk);
        chk[0] = 1'b1;
        a_chk("reset", 0, 0, 0);

        a_rst = 1'b0; a_en = 1'b1; a_up = 1'b1; a_sat = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a_chk("upwrap", (i + 1) % M, i == 9 ? 1 : 0, i >= 9 ? 1 : 0);
        end

        a_ld = 1'b1; a_lv = 4'd0;
        @(negedge clk);
        a_chk("load0", 0, 0, 1);
        a_ld = 1'b0; a_up = 1'b0;
        @(negedge clk);
        a_chk("downwrap", 9, 1, 1);
        a_ld = 1'b1;
        @(negedge clk);
        a_chk("reload0", 0, 0, 1);
        a_ld = 1'b0; a_sat = 1'b1;
        repeat (2) begin
            @(negedge clk);
            a_chk("downsat", 0, 0, 1);
        end

        a_en = 1'b0; a_clr = 1'b1;
        @(negedge clk);
        a_chk("clr_alone", 0, 0, 0);
        a_en = 1'b1;
        @(negedge clk);
        a_chk("clr_vs_step", 0, 0, 1);
        a_clr = 1'b0;

        a_up = 1'b1; a_ld = 1'b1; a_lv = 4'd6;
        @(negedge clk);
        a_chk("load6", 6, 0, 1);
        a_lv = 4'd15;
        @(negedge clk);
        a_chk("load15", 9, 0, 1);
        a_ld = 1'b0;
        @(negedge clk);
        a_chk("upsat", 9, 0, 1);

        a_ld = 1'b1; a_lv = 4'd7;
        @(negedge clk);
        a_chk("load7", 7, 0, 1);
        a_rst = 1'b1; a_lv = 4'd3;
        @(negedge clk);
        a_chk("rst_mid", 0, 0, 0);
        a_rst = 1'b0; a_ld = 1'b0; a_en = 1'b0;

        @(negedge clk);
        chk[1] = 1'b1;
        cmp("b_reset", int'(b_count), 0);
        b_rst = 1'b0; b_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            cmp("b_prescale", int'(b_count), exp_b[i]);
        end
        @(negedge clk);
        b_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cmp("b_hold", int'(b_count), 3);
        end
        b_en = 1'b1;
        @(negedge clk);
        cmp("b_resume1", int'(b_count), 3);
        @(negedge clk);
        cmp("b_resume2", int'(b_count), 4);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
